// File: rtl/shift_unit_iter_pkg.sv
// Shared op codes, FSM states and op classification for the iterative shift unit.
// Pure declarations: no latency, no flow control.
package shift_pkg;

    localparam logic [2:0] OP_SLL     = 3'b000;
    localparam logic [2:0] OP_SLL_ALT = 3'b001;
    localparam logic [2:0] OP_SRL     = 3'b010;
    localparam logic [2:0] OP_SRA     = 3'b011;
    localparam logic [2:0] OP_ROL     = 3'b100;
    localparam logic [2:0] OP_ROR     = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/shift_unit_iter_step.sv
// One shift increment of 0..STEP positions in any mode; purely combinational,
// zero latency, no flow control. Reserved ops pass the data through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int NW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [NW-1:0]    i_n,
    input  logic [2:0]       i_op,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    logic [31:0]      w_n32;
    logic [31:0]      w_comp;
    logic [WIDTH-1:0] w_fill_mask;

    always_comb begin
        w_n32       = 32'(i_n);
        w_comp      = 32'(WIDTH) - w_n32;
        // SRA fill comes from the operand's original MSB, not the working value
        w_fill_mask = i_fill ? ~({WIDTH{1'b1}} >> w_n32) : '0;
        o_data      = i_data;
        case (i_op)
            OP_SLL, OP_SLL_ALT: o_data = i_data << w_n32;
            OP_SRL:             o_data = i_data >> w_n32;
            OP_SRA:             o_data = (i_data >> w_n32) | w_fill_mask;
            OP_ROL:             o_data = (i_data << w_n32) | (i_data >> w_comp);
            OP_ROR:             o_data = (i_data >> w_n32) | (i_data << w_comp);
            default:            o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative shifter: up to STEP positions per cycle, result after max(1, ceil(amt/STEP)) edges.
// Result held in DONE until out_ready; in_ready only in IDLE; flush aborts any op.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int   WIDTH = 32,
    parameter int   STEP  = 4,
    localparam int  SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal
);

    localparam int NW = $clog2(STEP + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_rem;
    logic [2:0]       r_op;
    logic             r_sign;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_illegal;

    logic             w_idle;
    logic             w_accept;
    logic             w_to_done;
    logic [WIDTH-1:0] w_src_data;
    logic [2:0]       w_src_op;
    logic             w_src_fill;
    logic [31:0]      w_src_rem;
    logic [31:0]      w_n32;
    logic [SHW-1:0]   w_rem_nxt;
    logic [NW-1:0]    w_step_n;
    logic [WIDTH-1:0] w_step_out;

    assign w_idle      = (r_state == IDLE);
    assign in_ready    = w_idle;
    assign out_valid   = (r_state == DONE);
    assign out_data    = r_out_data;
    assign out_illegal = r_out_illegal;

    // In IDLE the first increment is taken straight from the request inputs
    always_comb begin
        w_src_data = w_idle ? in_data : r_work;
        w_src_op   = w_idle ? in_op : r_op;
        w_src_fill = w_idle ? in_data[WIDTH-1] : r_sign;
        w_src_rem  = w_idle ? 32'(in_amt) : 32'(r_rem);
        w_n32      = '0;
        if (!op_is_reserved(w_src_op)) begin
            w_n32 = (w_src_rem <= 32'(STEP)) ? w_src_rem : 32'(STEP);
        end
        w_rem_nxt  = op_is_reserved(w_src_op) ? '0 : SHW'(w_src_rem - w_n32);
        w_step_n   = NW'(w_n32);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .NW    (NW)
    ) u_step (
        .i_data (w_src_data),
        .i_n    (w_step_n),
        .i_op   (w_src_op),
        .i_fill (w_src_fill),
        .o_data (w_step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_rem_nxt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_rem_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
        end
        w_to_done = (w_state_nxt == DONE) && (r_state != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work        <= '0;
            r_rem         <= '0;
            r_op          <= '0;
            r_sign        <= 1'b0;
            r_out_data    <= '0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_out_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= in_op;
                r_sign <= in_data[WIDTH-1];
            end
            if (w_accept || (r_state == RUN)) begin
                r_work <= w_step_out;
                r_rem  <= w_rem_nxt;
            end
            if (w_to_done) begin
                r_out_data    <= w_step_out;
                r_out_illegal <= op_is_reserved(w_src_op);
            end
        end
    end

endmodule
